// File: rtl/seq_det_pkg.sv
// Shared definitions for the overlapping 0110 sequence detector.
//   SEQ_LEN : number of bits in the detected pattern
//   state_t : FSM state encoding; each state's code is the number of
//             pattern bits matched so far, codes 101-111 are illegal
package seq_det_pkg;

    localparam int unsigned SEQ_LEN = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        S0    = 3'b001,
        S01   = 3'b010,
        S011  = 3'b011,
        // The full-match state's code is the pattern length, i.e. 3'b100.
        S0110 = 3'(SEQ_LEN)
    } state_t;

endpackage

// File: rtl/overlapping_sequence_detector_0110.sv
// Moore FSM that flags the serial pattern 0-1-1-0 on data_in, with overlap:
// the trailing 0 of one match is reused as the leading 0 of the next.
//
// Ports:
//   clk      : system clock, all state updates on its rising edge
//   reset    : asynchronous, active-low reset; forces state IDLE
//   en       : sample enable; data_in is consumed only when en=1
//   data_in  : serial data bit
//   detected : high while the FSM sits in S0110 (decoded from the state
//              register only, so it is glitch-free and one enabled cycle long)
module overlapping_sequence_detector_0110
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic data_in,
    output logic detected
);

    state_t state_q;
    state_t state_d;

    // Next-state logic. Transitions follow the longest pattern prefix that
    // is still a suffix of the bits seen so far.
    always_comb begin
        // NOTE: every path assigns state_d via this default, so no latch is inferred.
        state_d = IDLE;
        if (!en) begin
            state_d = state_q;
        end else begin
            case (state_q)
                IDLE:    state_d = data_in ? IDLE : S0;
                S0:      state_d = data_in ? S01  : S0;
                S01:     state_d = data_in ? S011 : S0;
                // A fourth 1 shares no prefix with 0110, so restart from IDLE.
                S011:    state_d = data_in ? IDLE : S0110;
                // Overlap: the final 0 just matched doubles as a leading 0.
                S0110:   state_d = data_in ? S01  : S0;
                // Illegal codes recover to IDLE on the next enabled edge.
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output: a pure decode of the registered state.
    assign detected = (state_q == S0110);

endmodule

// File: tb/tb_overlapping_sequence_detector_0110.sv
// Self-checking bench for overlapping_sequence_detector_0110.
// A reference model keeps the last four enabled bits since reset; the
// expected detected value after each edge is pushed to a scoreboard queue
// when the stimulus is driven and popped when the DUT output is sampled.
module tb_overlapping_sequence_detector_0110;

    logic clk;
    logic reset;
    logic en;
    logic data_in;
    logic detected;

    int checks = 0;
    int errors = 0;

    // Reference model: history of enabled bits, newest in bit 0. Filled with
    // 1s after reset so no false 0110 can form from stale bits.
    logic [3:0] hist;
    logic       model_det;
    logic       sb_q[$];

    overlapping_sequence_detector_0110 dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .data_in  (data_in),
        .detected (detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        hist      = 4'b1111;
        model_det = 1'b0;
    endtask

    // Drive one cycle of stimulus, push the model's expectation, and return
    // 1 time unit after the rising edge with the DUT output settled.
    task automatic drive_bit(input logic e, input logic b);
        @(negedge clk);
        en      = e;
        data_in = b;
        if (e) begin
            hist      = {hist[2:0], b};
            model_det = (hist == 4'b0110);
        end
        sb_q.push_back(model_det);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_det;
        reset   = 1'b0;
        en      = 1'b1;
        data_in = 1'b1;
        model_reset();
        #1;
        checks++;
        if (detected !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: detected=%b expected=0", detected);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (detected !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: detected=%b expected=0", i, detected);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        drive_bit(1'b1, 1'b1);
        exp_det = sb_q.pop_front();
        checks++;
        if (detected !== exp_det) begin
            errors++;
            $display("FAIL reset_release: detected=%b expected=%b", detected, exp_det);
        end
    endtask

    task automatic test_simple_match();
        // 111 flush to IDLE, then 0,1,1,0,1
        logic [7:0] bits = 8'b111_01101;
        logic exp_det;
        for (int i = 7; i >= 0; i--) begin
            drive_bit(1'b1, bits[i]);
            exp_det = sb_q.pop_front();
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL simple_match step %0d: detected=%b expected=%b", 7 - i, detected, exp_det);
            end
            if (i == 1) begin
                checks++;
                if (detected !== 1'b1) begin
                    errors++;
                    $display("FAIL simple_match_pulse: detected=%b expected=1", detected);
                end
            end
        end
    endtask

    task automatic test_overlap();
        // 111 flush, then 0110 110 110
        logic [12:0] bits = 13'b111_0110110110;
        logic exp_det;
        int pulses = 0;
        for (int i = 12; i >= 0; i--) begin
            drive_bit(1'b1, bits[i]);
            exp_det = sb_q.pop_front();
            if (detected === 1'b1) pulses++;
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL overlap step %0d: detected=%b expected=%b", 12 - i, detected, exp_det);
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL overlap_pulse_count: got=%0d expected=3", pulses);
        end
    endtask

    task automatic test_broken_prefix();
        // 111 flush, 0111 (no match, back to IDLE), then 0110
        logic [10:0] bits = 11'b111_0111_0110;
        logic exp_det;
        int pulses = 0;
        for (int i = 10; i >= 0; i--) begin
            drive_bit(1'b1, bits[i]);
            exp_det = sb_q.pop_front();
            if (detected === 1'b1) pulses++;
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL broken_prefix step %0d: detected=%b expected=%b", 10 - i, detected, exp_det);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL broken_prefix_pulse_count: got=%0d expected=1", pulses);
        end
    endtask

    task automatic test_leading_zeros();
        // 111 flush, then 000110
        logic [8:0] bits = 9'b111_000110;
        logic exp_det;
        int pulses = 0;
        for (int i = 8; i >= 0; i--) begin
            drive_bit(1'b1, bits[i]);
            exp_det = sb_q.pop_front();
            if (detected === 1'b1) pulses++;
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL leading_zeros step %0d: detected=%b expected=%b", 8 - i, detected, exp_det);
            end
        end
        checks++;
        if (pulses != 1 || detected !== 1'b1) begin
            errors++;
            $display("FAIL leading_zeros_pulse: pulses=%0d last=%b expected pulses=1 last=1", pulses, detected);
        end
    endtask

    task automatic test_enable_gating();
        // flush 111, then (en,bit): 1/0 1/1 1/1 0/1 0/0 0/1 1/0 0/1 0/0 1/1
        logic [12:0] en_v  = 13'b111_1110001001;
        logic [12:0] bit_v = 13'b111_0111010101;
        logic exp_det;
        int high_cycles = 0;
        for (int i = 12; i >= 0; i--) begin
            drive_bit(en_v[i], bit_v[i]);
            exp_det = sb_q.pop_front();
            if (detected === 1'b1) high_cycles++;
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL enable_gating step %0d: detected=%b expected=%b", 12 - i, detected, exp_det);
            end
        end
        // detected high at the matching edge plus two disabled cycles
        checks++;
        if (high_cycles != 3) begin
            errors++;
            $display("FAIL enable_gating_hold: high_cycles=%0d expected=3", high_cycles);
        end
    endtask

    task automatic test_async_reset();
        // Reach S0110, then assert reset between edges: output must clear at once.
        logic [6:0] bits = 7'b111_0110;
        logic exp_det;
        for (int i = 6; i >= 0; i--) begin
            drive_bit(1'b1, bits[i]);
            exp_det = sb_q.pop_front();
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL async_reset_setup step %0d: detected=%b expected=%b", 6 - i, detected, exp_det);
            end
        end
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (detected !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: detected=%b expected=0", detected);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_sequence();
        // 111 0 1 1, reset, then 0 must not complete; 0 1 1 0 afterwards does.
        logic [5:0] pre  = 6'b111_011;
        logic [4:0] post = 5'b0_0110;
        logic exp_det;
        for (int i = 5; i >= 0; i--) begin
            drive_bit(1'b1, pre[i]);
            exp_det = sb_q.pop_front();
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL reset_mid_pre step %0d: detected=%b expected=%b", 5 - i, detected, exp_det);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(1'b1, post[i]);
            exp_det = sb_q.pop_front();
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL reset_mid_post step %0d: detected=%b expected=%b", 4 - i, detected, exp_det);
            end
        end
    endtask

    task automatic test_random();
        logic exp_det;
        for (int i = 0; i < 400; i++) begin
            drive_bit(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            exp_det = sb_q.pop_front();
            checks++;
            if (detected !== exp_det) begin
                errors++;
                $display("FAIL random step %0d: detected=%b expected=%b", i, detected, exp_det);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b0;
        data_in = 1'b0;
        model_reset();

        test_reset();
        test_simple_match();
        test_overlap();
        test_broken_prefix();
        test_leading_zeros();
        test_enable_gating();
        test_async_reset();
        test_reset_mid_sequence();
        test_random();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlapping_sequence_detector_0110.md
Name: overlapping_sequence_detector_0110

Overview:
Moore finite-state machine that detects the serial bit pattern 0-1-1-0 on a one-bit input stream, with overlap allowed. The trailing 0 of a match can start the next match. It sits on a serial data path as a pattern flag generator. Its output is a registered one-cycle pulse that asserts in the cycle after the final 0 is sampled.

Parameters:
None. The pattern 0110 is fixed; the state encoding is a package constant.

Ports:
clk  input  1  system clock; all state updates occur on its rising edge
reset  input  1  asynchronous, active-low reset; the name is kept per codebase convention; 0 forces state IDLE immediately
en  input  1  sample enable; data_in is consumed only on rising edges where en=1
data_in  input  1  serial data bit, sampled on the rising edge of clk
detected  output  1  high while the FSM is in state S0110; Moore output, decoded from the state register only

Behaviour:
- State register is 3 bits. Encoding: IDLE=000, S0=001, S01=010, S011=011, S0110=100. Codes 101–111 are illegal and go to IDLE on the next enabled edge.
- Reset (reset=0, asynchronous): state=IDLE and detected=0 immediately. Both are held while reset=0. Reset mid-sequence discards all partial progress.
- First enabled rising edge after reset deasserts: normal operation resumes.
- On a rising edge with en=1, transitions are:
  - IDLE: 0→S0, 1→IDLE
  - S0: 0→S0, 1→S01
  - S01: 0→S0, 1→S011
  - S011: 0→S0110, 1→IDLE
  - S0110: 0→S0, 1→S01 (overlap: the final 0 is reused as the leading 0)
- On a rising edge with en=0: state holds and detected holds.
- detected = (state == S0110). There is no combinational path from data_in or en to detected.
- Latency: detected rises at the same rising edge that samples the final 0. It is visible after clock-to-q and stays high for exactly one enabled cycle. It stays high longer only if en is low.
- Back-to-back overlapping matches: the stream 0110110 gives a detected pulse for 0110 and another for the overlapped 0110. Minimum spacing between pulses is 3 enabled cycles.
- Wrong bit in S011 (a 1): go to IDLE, not S0. The sequence 0111 gives no detection.
- Repeated 0s keep the FSM in S0.

Decomposition:
- Shared package seq_det_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, S0, S01, S011, S0110} with the explicit codes above
  - the pattern length constant SEQ_LEN=4
- One sequential always block for the state register with asynchronous active-low reset.
- One combinational always block for next-state logic, with a default assignment of IDLE.
- A continuous assign for detected.
- No sub-module; the FSM is self-contained.

Test Plan:
- Reset: hold reset=0 for 2 cycles → state=IDLE, detected=0. Drive data_in=1 during reset → no change.
- Simple match: after reset deasserts, en=1, bits 0,1,1,0 → detected=1 right after the 4th edge, and 0 on the next edge if data_in=1.
- Overlap: 0,1,1,0 then 1,1,0 then 1,1,0 → three detected pulses, each in the cycle after each final 0.
- Broken prefix: 0,1,1,1 → detected=0 and state=IDLE. Then 0,1,1,0 → detected=1.
- Leading zeros: 0,0,0,1,1,0 → single detected pulse after the final 0; no pulse before it.
- Enable gating: bits 0,1,1 with en=1, then en=0 for 3 cycles with data_in toggling, then en=1 with bit 0 → detected=1. With en=0 during a match cycle, detected stays high until the next enabled edge.
